// File: rtl/wptr_full_handler.sv
// Write-side pointer, full/almost-full and fill-level tracking for an async FIFO.
// Every output is registered; g_rptr_sync arrives already synchronized into wclk.
module wptr_full_handler #(
   parameter int unsigned PTR_WIDTH = 3,
   parameter int unsigned AFULL_TH  = 6
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr_sync,
   input  logic                 clr_ovf,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wlevel,
   output logic                 w_ack,
   output logic                 overflow
);

   localparam logic [PTR_WIDTH:0] AfullTh = AFULL_TH[PTR_WIDTH:0];

   logic                wr_ok;
   logic [PTR_WIDTH:0]  b_wptr_next;
   logic [PTR_WIDTH:0]  g_wptr_next;
   logic [PTR_WIDTH:0]  b_rptr_s;
   logic [PTR_WIDTH:0]  wlevel_next;
   logic                full_next;
   logic                almost_full_next;
   logic                overflow_next;

   assign wr_ok       = w_en & ~full;
   assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_ok};
   assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted.
   assign full_next = (g_wptr_next ==
                       {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]});

   always_comb begin
      b_rptr_s            = '0;
      b_rptr_s[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
      for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
         b_rptr_s[i] = b_rptr_s[i+1] ^ g_rptr_sync[i];
      end
   end

   // Modular subtraction keeps the level correct across pointer wrap.
   assign wlevel_next      = b_wptr_next - b_rptr_s;
   assign almost_full_next = (wlevel_next >= AfullTh);

   // A set in the same cycle as a clear wins.
   always_comb begin
      overflow_next = overflow;
      if (w_en && full) begin
         overflow_next = 1'b1;
      end else if (clr_ovf) begin
         overflow_next = 1'b0;
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wlevel      <= '0;
         w_ack       <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         b_wptr      <= b_wptr_next;
         g_wptr      <= g_wptr_next;
         full        <= full_next;
         almost_full <= almost_full_next;
         wlevel      <= wlevel_next;
         w_ack       <= wr_ok;
         overflow    <= overflow_next;
      end
   end

endmodule
